// File: rtl/srv1_bp_pkg.sv
// srv1_bp_pkg: shared types for the branch predictor controller
package srv1_bp_pkg;
    typedef enum logic {BPC_RUN, BPC_RECOVER} bpc_state_t;
    // One in-flight branch; room to add PC/target fields later.
    typedef struct packed {
        logic pred;
    } bp_entry_t;
endpackage

// File: rtl/bp_fifo.sv
// bp_fifo: in-order queue of in-flight predicted branches
// Ports: clk, sync_rst (sync, active-high); push/push_data, pop, clear (wins over push);
//        head = oldest entry; full, empty, count = occupancy.
module bp_fifo
    import srv1_bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     sync_rst,
    input  logic                     push,
    input  bp_entry_t                push_data,
    input  logic                     pop,
    input  logic                     clear,
    output bp_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    bp_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    assign head  = mem_q[rd_q];
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d  = clear ? '0 : wr_q + AW'(push);
        rd_d  = clear ? '0 : rd_q + AW'(pop);
        cnt_d = clear ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_q] <= push_data;
    end
endmodule

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: sequences the global-history branch predictor
// Ports: clk, sync_rst (sync, active-high), clk_en (0 = hold everything);
//        alloc_valid/alloc_pred/alloc_ready from fetch; resolve_valid/resolve_taken from execute;
//        fb_enable/fb_result to branch_pred; mispredict pulse; inflight occupancy;
//        err_underflow sticky; branch_cnt/mispred_cnt saturating statistics.
module branch_pred_ctrl
    import srv1_bp_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNTW           = 16
) (
    input  logic                   clk,
    input  logic                   sync_rst,
    input  logic                   clk_en,
    input  logic                   alloc_valid,
    input  logic                   alloc_pred,
    output logic                   alloc_ready,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    output logic                   fb_enable,
    output logic                   fb_result,
    output logic                   mispredict,
    output logic [$clog2(DEPTH):0] inflight,
    output logic                   err_underflow,
    output logic [CNTW-1:0]        branch_cnt,
    output logic [CNTW-1:0]        mispred_cnt
);
    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    bpc_state_t    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          fb_enable_q, fb_enable_d, fb_result_q, fb_result_d;
    logic          mispredict_q, mispredict_d, err_q, err_d;
    logic [CNTW-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
    logic          full, empty, alloc_fire, resolve_fire, mis;
    bp_entry_t     head, push_entry;
    assign push_entry.pred = alloc_pred;
    assign alloc_ready     = (state_q == BPC_RUN) && !full;
    assign alloc_fire      = clk_en && alloc_valid && alloc_ready;
    assign resolve_fire    = clk_en && resolve_valid && !empty;
    assign mis             = resolve_fire && (head.pred != resolve_taken);
    // A mispredict flushes the whole queue: every queued entry is younger than the head.
    bp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .push      (alloc_fire),
        .push_data (push_entry),
        .pop       (resolve_fire),
        .clear     (mis),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (inflight)
    );
    always_comb begin
        fb_enable_d   = clk_en ? resolve_fire : fb_enable_q;
        fb_result_d   = resolve_fire ? resolve_taken : fb_result_q;
        mispredict_d  = clk_en ? mis : mispredict_q;
        err_d         = err_q | (clk_en & resolve_valid & empty);
        branch_cnt_d  = branch_cnt_q + CNTW'(resolve_fire && !(&branch_cnt_q));
        mispred_cnt_d = mispred_cnt_q + CNTW'(mis && !(&mispred_cnt_q));
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        if (clk_en) begin
            if (state_q == BPC_RUN) begin
                if (mis && RECOVER_CYCLES > 0) begin
                    state_d = BPC_RECOVER;
                    rcnt_d  = RW'(RECOVER_CYCLES - 1);
                end
            end else if (rcnt_q == '0) begin
                state_d = BPC_RUN;
            end else begin
                rcnt_d = rcnt_q - RW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q       <= BPC_RUN;
            rcnt_q        <= '0;
            fb_enable_q   <= 1'b0;
            fb_result_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            err_q         <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            rcnt_q        <= rcnt_d;
            fb_enable_q   <= fb_enable_d;
            fb_result_q   <= fb_result_d;
            mispredict_q  <= mispredict_d;
            err_q         <= err_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
    assign fb_enable     = fb_enable_q;
    assign fb_result     = fb_result_q;
    assign mispredict    = mispredict_q;
    assign err_underflow = err_q;
    assign branch_cnt    = branch_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: scoreboard bench for branch_pred_ctrl
module tb_branch_pred_ctrl;
    localparam int DEPTH = 4;
    localparam int RC    = 2;
    logic clk = 1'b0;
    logic sync_rst, clk_en, alloc_valid, alloc_pred, resolve_valid, resolve_taken;
    logic alloc_ready, fb_enable, fb_result, mispredict, err_underflow;
    logic [2:0] inflight;
    logic [15:0] branch_cnt, mispred_cnt;
    logic a4_ready, fe4, fr4, mp4, err4;
    logic [2:0] inf4;
    logic [3:0] bc4, mc4;
    int total = 0, bad = 0;
    typedef struct { bit fe; bit fr; bit mp; } exp_t;
    exp_t exp_q[$];
    exp_t e;
    bit m_q[$];
    int m_block, m_bcnt, m_mcnt;
    bit m_err, last_fe, last_fr, last_mp;

    branch_pred_ctrl #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC), .CNTW(16)) dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .alloc_valid(alloc_valid), .alloc_pred(alloc_pred), .alloc_ready(alloc_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .fb_enable(fb_enable), .fb_result(fb_result), .mispredict(mispredict),
        .inflight(inflight), .err_underflow(err_underflow),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt));

    branch_pred_ctrl #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC), .CNTW(4)) dut4 (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .alloc_valid(alloc_valid), .alloc_pred(alloc_pred), .alloc_ready(a4_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .fb_enable(fe4), .fb_result(fr4), .mispredict(mp4),
        .inflight(inf4), .err_underflow(err4),
        .branch_cnt(bc4), .mispred_cnt(mc4));

    always #5 clk = ~clk;

    function automatic bit m_rdy();
        return (m_block == 0) && (m_q.size() < DEPTH);
    endfunction

    task automatic do_reset();
        sync_rst = 1'b1; clk_en = 1'b1;
        alloc_valid = 1'b0; alloc_pred = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sync_rst = 1'b0;
        m_q.delete(); exp_q.delete();
        m_block = 0; m_bcnt = 0; m_mcnt = 0;
        m_err = 0; last_fe = 0; last_fr = 0; last_mp = 0;
    endtask

    // Drives one cycle, advances the reference model and queues the expected registered outputs.
    task automatic cyc(input bit en, input bit av, input bit ap, input bit rv, input bit rt);
        bit af, rf, mis;
        exp_t x;
        clk_en = en; alloc_valid = av; alloc_pred = ap; resolve_valid = rv; resolve_taken = rt;
        af  = en && av && m_rdy();
        rf  = en && rv && (m_q.size() != 0);
        mis = rf && (m_q[0] != rt);
        if (en) begin
            last_fe = rf;
            if (rf) last_fr = rt;
            last_mp = mis;
        end
        x.fe = last_fe; x.fr = last_fr; x.mp = last_mp;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (en) begin
            if (rv && m_q.size() == 0) m_err = 1;
            if (rf) begin void'(m_q.pop_front()); m_bcnt++; end
            if (mis) m_mcnt++;
            if (af) m_q.push_back(ap);
            if (mis) begin m_q.delete(); m_block = RC; end
            else if (m_block > 0) m_block--;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (alloc_ready !== 1'b1 || inflight !== 3'd0 || fb_enable !== 1'b0 || mispredict !== 1'b0 ||
            err_underflow !== 1'b0 || branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset: got rdy=%b inf=%0d fe=%b mp=%b err=%b bc=%0d mc=%0d want 1 0 0 0 0 0 0",
                     alloc_ready, inflight, fb_enable, mispredict, err_underflow, branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 1, 0, 0);
            e = exp_q.pop_front();
            total++;
            if (inflight !== 3'(m_q.size()) || alloc_ready !== m_rdy() || fb_enable !== e.fe) begin
                bad++;
                $display("FAIL fill[%0d]: got inf=%0d rdy=%b fe=%b want %0d %b %b",
                         i, inflight, alloc_ready, fb_enable, m_q.size(), m_rdy(), e.fe);
            end
        end
        total++;
        if (inflight !== 3'd4 || alloc_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full: got inf=%0d rdy=%b want 4 0", inflight, alloc_ready);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 1, 1);
            e = exp_q.pop_front();
            total++;
            if (fb_enable !== 1'b1 || fb_result !== 1'b1 || mispredict !== 1'b0 ||
                fb_enable !== e.fe || fb_result !== e.fr) begin
                bad++;
                $display("FAIL drain[%0d]: got fe=%b fr=%b mp=%b want 1 1 0", i, fb_enable, fb_result, mispredict);
            end
        end
        total++;
        if (branch_cnt !== 16'd4 || mispred_cnt !== 16'd0 || inflight !== 3'd0) begin
            bad++;
            $display("FAIL drain_cnt: got bc=%0d mc=%0d inf=%0d want 4 0 0", branch_cnt, mispred_cnt, inflight);
        end
    endtask

    task automatic test_mispredict();
        cyc(1, 1, 0, 0, 0); cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0);
        exp_q.delete();
        cyc(1, 0, 0, 1, 1);
        e = exp_q.pop_front();
        total++;
        if (mispredict !== 1'b1 || e.mp !== 1'b1 || fb_enable !== 1'b1 || fb_result !== 1'b1 ||
            inflight !== 3'd0 || alloc_ready !== 1'b0 || mispred_cnt !== 16'd1) begin
            bad++;
            $display("FAIL mispredict: got mp=%b fe=%b fr=%b inf=%0d rdy=%b mc=%0d want 1 1 1 0 0 1",
                     mispredict, fb_enable, fb_result, inflight, alloc_ready, mispred_cnt);
        end
        cyc(1, 0, 0, 0, 0);
        e = exp_q.pop_front();
        total++;
        if (mispredict !== 1'b0 || alloc_ready !== 1'b0 || fb_enable !== 1'b0) begin
            bad++;
            $display("FAIL recover1: got mp=%b rdy=%b fe=%b want 0 0 0", mispredict, alloc_ready, fb_enable);
        end
        cyc(1, 0, 0, 0, 0);
        e = exp_q.pop_front();
        total++;
        if (alloc_ready !== 1'b1) begin
            bad++;
            $display("FAIL recover2: got rdy=%b want 1", alloc_ready);
        end
    endtask

    task automatic test_flush_alloc();
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 1, 0);
        exp_q.delete();
        total++;
        if (inflight !== 3'd0 || mispredict !== 1'b1 || fb_result !== 1'b0 || mispred_cnt !== 16'd2) begin
            bad++;
            $display("FAIL flush_alloc: got inf=%0d mp=%b fr=%b mc=%0d want 0 1 0 2",
                     inflight, mispredict, fb_result, mispred_cnt);
        end
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        cyc(1, 1, 1, 0, 0);
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, i[0], 1, m_q[0]);
            e = exp_q.pop_front();
            total++;
            if (inflight !== 3'd1 || fb_enable !== e.fe || fb_result !== e.fr || mispredict !== 1'b0) begin
                bad++;
                $display("FAIL b2b[%0d]: got inf=%0d fe=%b fr=%b mp=%b want 1 %b %b 0",
                         i, inflight, fb_enable, fb_result, mispredict, e.fe, e.fr);
            end
        end
        cyc(1, 0, 0, 1, m_q[0]);
        exp_q.delete();
        total++;
        if (inflight !== 3'd0) begin
            bad++;
            $display("FAIL b2b_end: got inf=%0d want 0", inflight);
        end
    endtask

    task automatic test_clk_en_hold();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 1);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 1, 1);
            e = exp_q.pop_front();
            total++;
            if (mispredict !== 1'b1 || fb_enable !== 1'b1 || alloc_ready !== 1'b0 || inflight !== 3'd0 ||
                mispred_cnt !== 16'(m_mcnt) || branch_cnt !== 16'(m_bcnt)) begin
                bad++;
                $display("FAIL hold[%0d]: got mp=%b fe=%b rdy=%b inf=%0d mc=%0d bc=%0d want 1 1 0 0 %0d %0d",
                         i, mispredict, fb_enable, alloc_ready, inflight, mispred_cnt, branch_cnt, m_mcnt, m_bcnt);
            end
        end
        cyc(1, 0, 0, 0, 0);
        e = exp_q.pop_front();
        total++;
        if (mispredict !== 1'b0 || alloc_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_resume1: got mp=%b rdy=%b want 0 0", mispredict, alloc_ready);
        end
        cyc(1, 0, 0, 0, 0);
        e = exp_q.pop_front();
        total++;
        if (alloc_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_resume2: got rdy=%b want 1", alloc_ready);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
            e = exp_q.pop_front();
            total++;
            if (fb_enable !== e.fe || fb_result !== e.fr || mispredict !== e.mp ||
                inflight !== 3'(m_q.size()) || alloc_ready !== m_rdy() || err_underflow !== m_err ||
                branch_cnt !== 16'(m_bcnt) || mispred_cnt !== 16'(m_mcnt)) begin
                bad++;
                $display("FAIL random[%0d]: got fe=%b fr=%b mp=%b inf=%0d rdy=%b err=%b bc=%0d mc=%0d want %b %b %b %0d %b %b %0d %0d",
                         i, fb_enable, fb_result, mispredict, inflight, alloc_ready, err_underflow, branch_cnt, mispred_cnt,
                         e.fe, e.fr, e.mp, m_q.size(), m_rdy(), m_err, m_bcnt, m_mcnt);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cyc(1, 0, 0, 1, 1);
        e = exp_q.pop_front();
        total++;
        if (fb_enable !== 1'b0 || err_underflow !== 1'b1 || branch_cnt !== 16'd0) begin
            bad++;
            $display("FAIL underflow: got fe=%b err=%b bc=%0d want 0 1 0", fb_enable, err_underflow, branch_cnt);
        end
        repeat (3) cyc(1, 1, 1, 0, 0);
        exp_q.delete();
        total++;
        if (err_underflow !== 1'b1) begin
            bad++;
            $display("FAIL underflow_sticky: got err=%b want 1", err_underflow);
        end
    endtask

    task automatic test_sync_rst_mid();
        sync_rst = 1'b1; clk_en = 1'b1;
        alloc_valid = 1'b1; alloc_pred = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (fb_enable !== 1'b0 || mispredict !== 1'b0 || inflight !== 3'd0 || err_underflow !== 1'b0 ||
            mispred_cnt !== 16'd0 || alloc_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid: got fe=%b mp=%b inf=%0d err=%b mc=%0d rdy=%b want 0 0 0 0 0 1",
                     fb_enable, mispredict, inflight, err_underflow, mispred_cnt, alloc_ready);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        cyc(1, 1, 1, 0, 0);
        for (int i = 0; i < 19; i++) cyc(1, 1, 1, 1, 1);
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 21; i++) begin
            e = exp_q.pop_front();
            if (i > 0 && (e.fe !== 1'b1 || e.mp !== 1'b0)) $display("note: unexpected model state at %0d", i);
        end
        total++;
        if (branch_cnt !== 16'd20 || bc4 !== 4'd15 || mc4 !== 4'd0 || fe4 !== 1'b1 || inf4 !== 3'd0) begin
            bad++;
            $display("FAIL saturate: got bc=%0d bc4=%0d mc4=%0d fe4=%b inf4=%0d want 20 15 0 1 0",
                     branch_cnt, bc4, mc4, fe4, inf4);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_mispredict();
        test_flush_alloc();
        test_back_to_back();
        test_clk_en_hold();
        test_random();
        test_underflow();
        test_sync_rst_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
